mdu_ctrl: RTL

//  Iterative multiply/divide unit (MDU) controller. It owns the HI/LO registers and sequences a radix-2 shift-add/shift-subtract datapath for MULT/MULTU/DIV/DIVU.
//  It also performs MTHI/MTLO writes. Sits beside the EX-stage ALU; decode issues mdu_op, and the pipeline stalls while busy is high.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter_step.sv | 34 +++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, FSM states.
// Used by mdu_ctrl and mdu_iter_step.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_SIGN = 2'd2
  } mdu_st_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring shift-subtract divide on {acc_hi, acc_lo}.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply adds into the high half then shifts right;
  // divide shifts left and keeps the difference if >= 0.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, operand};
    nxt    = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH])
        nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: FSM, sign handling and HI/LO.
// Optional single-cycle multiply: MDU_FAST_MULT_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_st_e            state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw1;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  logic               dec_mul;
  logic               dec_div;
  logic               dec_sgn;
  logic               dec_mthi;
  logic               dec_mtlo;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               accept;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_abs}
                   * {{WIDTH{1'b0}}, b_abs};
`endif

  assign busy   = (state != MDU_ST_IDLE);
  assign accept = start && (state == MDU_ST_IDLE) && !flush;

  // Decode the issued op and take magnitudes for signed ops.
  always_comb begin
    dec_mul  = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
    dec_div  = (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
    dec_sgn  = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
    dec_mthi = (mdu_op == MDU_MTHI);
    dec_mtlo = (mdu_op == MDU_MTLO);
    a_abs    = (dec_sgn && op1[WIDTH-1]) ? -op1 : op1;
    b_abs    = (dec_sgn && op2[WIDTH-1]) ? -op2 : op2;
  end

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc     (acc),
    .operand (opnd),
    .is_div  (is_div),
    .nxt     (acc_nxt)
  );

  // Sign fix-up and divide-by-zero result selection.
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = dz ? raw1 : rem;
      res_lo = dz ? '1 : quo;
    end
  end

  // Main FSM: accept, iterate, fix up and write HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MDU_ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      raw1    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MDU_ST_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              dec_mul: begin
                is_div  <= 1'b0;
                neg_res <= dec_sgn && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                neg_rem <= 1'b0;
                dz      <= 1'b0;
                opnd    <= a_abs;
                raw1    <= op1;
                cnt     <= '0;
`ifdef MDU_FAST_MULT_EN
                acc     <= fast_prod;
                state   <= MDU_ST_SIGN;
`else
                acc     <= {{WIDTH{1'b0}}, b_abs};
                state   <= MDU_ST_CALC;
`endif
              end
              dec_div: begin
                is_div  <= 1'b1;
                neg_res <= dec_sgn && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                neg_rem <= dec_sgn && op1[WIDTH-1];
                dz      <= (op2 == '0);
                opnd    <= b_abs;
                raw1    <= op1;
                acc     <= {{WIDTH{1'b0}}, a_abs};
                cnt     <= '0;
                state   <= MDU_ST_CALC;
              end
              dec_mthi: hi <= op1;
              dec_mtlo: lo <= op1;
              default: ;
            endcase
          end
        end
        MDU_ST_CALC: begin
          if (flush) begin
            state <= MDU_ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= MDU_ST_SIGN;
          end
        end
        MDU_ST_SIGN: begin
          state <= MDU_ST_IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: state <= MDU_ST_IDLE;
      endcase
    end
  end

endmodule
